// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and frame layout helpers for the PS/2 frame receiver.
//   rx_state_e  - receiver FSM state encoding
//   START_IDX   - bit position of the start bit in the assembled frame
//   frame_len() - total frame length for a given payload width
//   par_idx()   - bit position of the parity bit
//   stop_idx()  - bit position of the stop bit
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  localparam int START_IDX = 0;

  function automatic int frame_len(input int data_bits);
    return data_bits + 3;
  endfunction

  function automatic int par_idx(input int data_bits);
    return data_bits + 1;
  endfunction

  function automatic int stop_idx(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: input conditioning for the raw PS/2 lines.
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   ps2_clk_i  - raw PS/2 clock (asynchronous)
//   ps2_data_i - raw PS/2 data (asynchronous)
//   clk_f_o    - synchronised and debounced PS/2 clock
//   data_s_o   - synchronised PS/2 data
//   fall_o     - high in the first cycle clk_f_o reads low after being high
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_f_o,
  output logic data_s_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_s_q;
  logic [1:0]    data_s_q;
  logic          clk_f_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_s_q  <= 2'b11;
      data_s_q <= 2'b11;
      clk_f_q  <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s_q  <= {clk_s_q[0], ps2_clk_i};
      data_s_q <= {data_s_q[0], ps2_data_i};
      fall_q   <= 1'b0;
      // cnt_q counts consecutive samples that disagree with clk_f_q; the
      // FILTER_LEN-th such sample flips the filtered value.
      if (clk_s_q[1] != clk_f_q) begin
        if (cnt_q == CNT_LAST) begin
          clk_f_q <= clk_s_q[1];
          cnt_q   <= '0;
          fall_q  <= clk_f_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign clk_f_o  = clk_f_q;
  assign data_s_o = data_s_q[1];
  assign fall_o   = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with framing checks,
// stall watchdog and a valid/ack holding register.
//   sys_clk_i     - system clock
//   reset_i       - synchronous active-high reset
//   ps2_clk_i     - raw PS/2 clock line
//   ps2_data_i    - raw PS/2 data line
//   out_data_o    - last validated payload
//   out_valid_o   - out_data_o holds an unconsumed byte
//   out_ack_i     - consumer acknowledge, clears out_valid_o
//   overrun_o     - pulse: byte written over an unconsumed one
//   frame_err_o   - pulse: start, parity or stop check failed
//   timeout_err_o - pulse: watchdog aborted a stalled frame
//   busy_o        - receiver is not idle
//
// state | meaning
// IDLE  | waiting for a falling edge with data low (start bit)
// RECV  | shifting frame bits, watchdog running between edges
// CHECK | one cycle: validate frame and update holding register
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ODD_PARITY  = 1
) (
  input  logic                 sys_clk_i,
  input  logic                 reset_i,
  input  logic                 ps2_clk_i,
  input  logic                 ps2_data_i,
  output logic [DATA_BITS-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ack_i,
  output logic                 overrun_o,
  output logic                 frame_err_o,
  output logic                 timeout_err_o,
  output logic                 busy_o
);

  localparam int FL   = frame_len(DATA_BITS);
  localparam int PAR  = par_idx(DATA_BITS);
  localparam int STOP = stop_idx(DATA_BITS);
  localparam int BCW  = $clog2(FL + 1);
  localparam int WDW  = $clog2(TIMEOUT_CYC);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FL);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);
  localparam logic           ODD      = (ODD_PARITY != 0);

  logic clk_f, data_s, fall, fall_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_i      (sys_clk_i),
    .rst_i      (reset_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_f_o    (clk_f),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  // fall coincides with the filtered clock reading low.
  assign fall_ok = fall & ~clk_f;

  rx_state_e            state_q;
  logic [FL-1:0]        shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [DATA_BITS-1:0] out_data_q;
  logic                 out_valid_q, overrun_q, frame_err_q, timeout_q;
  logic                 frame_good;

  always_comb begin
    shift_d   = {data_s, shift_q[FL-1:1]};
    bit_cnt_d = bit_cnt_q + BCW'(1);
    wd_d      = (wd_q == '1) ? wd_q : wd_q + WDW'(1);
    frame_good = ~shift_q[START_IDX] & shift_q[STOP] &
                 ((^shift_q[PAR:1]) == ODD);
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (out_ack_i && out_valid_q) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_ok && !data_s) begin
            shift_q   <= shift_d;
            bit_cnt_q <= BCW'(1);
            wd_q      <= '0;
            state_q   <= RECV;
          end
        end
        RECV: begin
          if (fall_ok) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wd_q      <= '0;
            if (bit_cnt_d == BIT_LAST) state_q <= CHECK;
          end else begin
            wd_q <= wd_d;
            // Abort as the watchdog steps onto its last count so the pulse
            // lands TIMEOUT_CYC cycles after the last edge.
            if (wd_d == WD_LAST) begin
              timeout_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end
        end
        CHECK: begin
          if (frame_good) begin
            out_data_q  <= shift_q[DATA_BITS:1];
            out_valid_q <= 1'b1;
            overrun_q   <= out_valid_q & ~out_ack_i;
          end else begin
            frame_err_q <= 1'b1;
          end
          bit_cnt_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign overrun_o     = overrun_q;
  assign frame_err_o   = frame_err_q;
  assign timeout_err_o = timeout_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int DB   = 8;
  localparam int FLT  = 4;
  localparam int TO   = 1000;
  localparam int HALF = 250;   // 5 us half period at 50 MHz

  localparam int K_GOOD = 0;
  localparam int K_FERR = 1;
  localparam int K_TOUT = 2;
  localparam int K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pclk = 1'b1;
  logic          pdata = 1'b1;
  logic          ack = 1'b0;
  logic [DB-1:0] out_data;
  logic          out_valid, overrun, ferr, terr, busy;

  ps2_frame_rx #(
    .DATA_BITS(DB), .FILTER_LEN(FLT), .TIMEOUT_CYC(TO), .ODD_PARITY(1)
  ) dut (
    .sys_clk_i     (clk),
    .reset_i       (rst),
    .ps2_clk_i     (pclk),
    .ps2_data_i    (pdata),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ack_i     (ack),
    .overrun_o     (overrun),
    .frame_err_o   (ferr),
    .timeout_err_o (terr),
    .busy_o        (busy)
  );

  always #10 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           kind;
    logic [DB-1:0] data;
    logic         ovr;
    longint       cyc;
  } ev_t;

  ev_t  exp_q[$];
  logic model_valid = 1'b0;

  // Scoreboard monitor: any observable write or error pulse pops one entry.
  ev_t           mon_e;
  int            obs_kind;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_data  = '0;
    end else begin
      if (ferr || terr || overrun ||
          (out_valid && (!prev_valid || out_data != prev_data))) begin
        obs_kind = terr ? K_TOUT : (ferr ? K_FERR : K_GOOD);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d kind=%0d data=%h, required no event",
                   cyc, obs_kind, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (obs_kind !== mon_e.kind) begin
            errors++;
            $display("FAIL event_kind: got %0d, expected %0d", obs_kind, mon_e.kind);
          end
          checks++;
          if (cyc !== mon_e.cyc) begin
            errors++;
            $display("FAIL event_cycle: got %0d, expected %0d", cyc, mon_e.cyc);
          end
          if (mon_e.kind == K_GOOD) begin
            checks++;
            if (out_data !== mon_e.data) begin
              errors++;
              $display("FAIL out_data: got %h, expected %h", out_data, mon_e.data);
            end
            checks++;
            if (out_valid !== 1'b1) begin
              errors++;
              $display("FAIL out_valid_on_write: got %b, expected 1", out_valid);
            end
            checks++;
            if (overrun !== mon_e.ovr) begin
              errors++;
              $display("FAIL overrun: got %b, expected %b", overrun, mon_e.ovr);
            end
          end else if (mon_e.kind == K_TOUT) begin
            checks++;
            if (busy !== 1'b0) begin
              errors++;
              $display("FAIL busy_at_timeout: got %b, expected 0", busy);
            end
          end
        end
      end
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  task automatic wait_half(input bit g);
    repeat (HALF/2) @(negedge clk);
    if (g) begin
      pclk = ~pclk;
      @(negedge clk);
      pclk = ~pclk;
      repeat (HALF - HALF/2 - 1) @(negedge clk);
    end else begin
      repeat (HALF - HALF/2) @(negedge clk);
    end
  endtask

  // Drives nbits of a frame; pushes the expected event at the last falling edge.
  task automatic send_frame(input logic [DB-1:0] d, input int nbits, input int kind,
                            input bit flip_par, input bit glitch, input bit ack_chk);
    logic [DB+2:0] bits;
    logic          p;
    logic          ov;
    longint        r;
    ev_t           e;
    p    = (~^d) ^ flip_par;
    bits = {1'b1, p, d, 1'b0};
    ov   = model_valid & ~ack_chk;
    for (int i = 0; i < nbits; i++) begin
      pdata = bits[i];
      wait_half(glitch);
      pclk = 1'b0;
      r = cyc;
      if (i == nbits-1 && kind != K_NONE) begin
        e.kind = kind;
        e.data = d;
        e.ovr  = ov;
        e.cyc  = r + 2 + FLT + ((kind == K_TOUT) ? TO : 2);
        exp_q.push_back(e);
        if (kind == K_GOOD) model_valid = 1'b1;
      end
      if (ack_chk && i == nbits-1) begin
        // ack is sampled in the CHECK cycle only
        repeat (FLT + 3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (HALF - FLT - 4) @(negedge clk);
      end else begin
        wait_half(glitch);
      end
      pclk = 1'b1;
    end
    pdata = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_event: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_ack();
    logic [DB-1:0] d0;
    d0 = out_data;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    model_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== d0) begin
      errors++;
      $display("FAIL ack_clear: got valid=%b data=%h, expected valid=0 data=%h",
               out_valid, out_data, d0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_data, out_valid, overrun, ferr, terr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got data=%h v=%b o=%b fe=%b te=%b b=%b, expected all 0",
               out_data, out_valid, overrun, ferr, terr, busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 11, K_GOOD, 0, 0, 0);
    wait_drain(50);
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'hF0, 11, K_GOOD, 0, 0, 0);
    send_frame(8'h1C, 11, K_GOOD, 0, 0, 0);
    wait_drain(50);
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || out_data !== 8'h1C) begin
      errors++;
      $display("FAIL overrun_single_cycle: got o=%b data=%h, expected o=0 data=1c",
               overrun, out_data);
    end
    do_ack();
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 11, K_FERR, 1, 0, 0);
    wait_drain(50);
    checks++;
    if (out_valid !== 1'b0 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL parity_err_after: got v=%b fe=%b, expected v=0 fe=0", out_valid, ferr);
    end
  endtask

  task automatic test_timeout();
    send_frame(8'h55, 5, K_TOUT, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame: got %b, expected 1", busy);
    end
    wait_drain(TO + 200);
    checks++;
    if (busy !== 1'b0 || terr !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: got b=%b te=%b, expected 0 0", busy, terr);
    end
    send_frame(8'h1C, 11, K_GOOD, 0, 0, 0);
    wait_drain(50);
    do_ack();
  endtask

  task automatic test_glitch();
    send_frame(8'h5A, 11, K_GOOD, 0, 1, 0);
    wait_drain(50);
    checks++;
    if (out_data !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_data: got %h, expected 5a", out_data);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_and_ack();
    send_frame(8'h29, 6, K_NONE, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: got %b, expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got b=%b v=%b, expected 0 0", busy, out_valid);
    end
    model_valid = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 11, K_GOOD, 0, 0, 0);
    wait_drain(50);
    send_frame(8'h77, 11, K_GOOD, 0, 0, 1);
    wait_drain(50);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      errors++;
      $display("FAIL ack_in_check: got v=%b data=%h, expected v=1 data=77",
               out_valid, out_data);
    end
    do_ack();
    do_ack();  // ack with nothing pending is ignored
  endtask

  initial begin
    #(1_800_000);
    $display("FAIL global_timeout: got cyc=%0d, expected finish before it", cyc);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_mid_and_ack();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
